// File: rtl/mine_field_gen.sv
// mine_field_gen: places a configurable number of mines on a ROWS x COLS board
// with an LCG (bounded retry, then linear-probe fallback), then answers
// neighbour-count queries by visiting one neighbour per cycle.
// Optional feature macro: SAFE_FIRST_EN (keeps in_safe_idx mine-free).
module mine_field_gen #(
  parameter int ROWS      = 5,
  parameter int COLS      = 5,
  parameter int IDX_W     = 5,
  parameter int RETRY_MAX = 4
) (
  input  logic                 in_clka,
  input  logic                 in_restart,
  input  logic                 in_place,
  input  logic [IDX_W-1:0]     in_seed,
  input  logic [IDX_W-1:0]     in_mult,
  input  logic [IDX_W-1:0]     in_incr,
  input  logic [IDX_W-1:0]     in_n_mines,
  input  logic [IDX_W-1:0]     in_safe_idx,
  input  logic                 in_query,
  input  logic [IDX_W-1:0]     in_query_idx,
  output logic                 out_busy,
  output logic                 out_field_valid,
  output logic                 out_place_done,
  output logic [ROWS*COLS-1:0] out_mines,
  output logic [IDX_W-1:0]     out_temp_index,
  output logic [IDX_W-1:0]     out_temp_mine_cnt,
  output logic                 out_query_valid,
  output logic                 out_query_hit,
  output logic [3:0]           out_n_nearby
);

  localparam int CELLS = ROWS * COLS;
`ifdef SAFE_FIRST_EN
  localparam int CLAMP = CELLS - 2;  // one cell reserved for the safe index
`else
  localparam int CLAMP = CELLS - 1;  // at least one free cell always remains
`endif

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_PLACE, ST_PROBE, ST_DONE, ST_QUERY, ST_REPORT
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] target;
  logic [7:0]       rej_cnt;
  logic [IDX_W-1:0] probe_ptr;
  logic [IDX_W-1:0] q_idx;
  logic [2:0]       step;
  logic [3:0]       acc;

`ifdef SAFE_FIRST_EN
  logic [IDX_W-1:0] safe_idx;
`else
  logic unused_safe;
  assign unused_safe = ^in_safe_idx;
`endif

  // Combinational helpers: next LCG candidate, free-cell tests, clamped target
  logic [IDX_W-1:0] cand;
  logic             cand_free;
  logic             probe_free;
  logic [IDX_W-1:0] count_inc;
  logic             target_hit;
  logic [IDX_W-1:0] target_next;

  assign out_busy = (state != ST_IDLE);

  // Candidate generation and occupancy checks for PLACE and PROBE
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    cand        = out_temp_index * in_mult + in_incr;
    cand_free   = 1'b0;
    probe_free  = 1'b0;
    if (int'(cand) < CELLS)      cand_free  = !out_mines[cand];
    if (int'(probe_ptr) < CELLS) probe_free = !out_mines[probe_ptr];
`ifdef SAFE_FIRST_EN
    if (cand == safe_idx)      cand_free  = 1'b0;
    if (probe_ptr == safe_idx) probe_free = 1'b0;
`endif
    count_inc   = out_temp_mine_cnt + IDX_W'(1);
    target_hit  = (count_inc == target);
    target_next = (int'(in_n_mines) > CLAMP) ? IDX_W'(CLAMP) : in_n_mines;
  end

  // Neighbour selection for the current QUERY step (NW,N,NE,W,E,SW,S,SE)
  logic q_in_range;
  logic nb_mine;
  logic q_hit;
  int   q_row, q_col, dr, dc, nr, nc;

  always_comb begin
    q_in_range = (int'(q_idx) < CELLS);
    q_row      = int'(q_idx) / COLS;
    q_col      = int'(q_idx) % COLS;
    dr         = 0;
    dc         = 0;
    case (step)
      3'd0: begin dr = -1; dc = -1; end
      3'd1: begin dr = -1; dc =  0; end
      3'd2: begin dr = -1; dc =  1; end
      3'd3: begin dr =  0; dc = -1; end
      3'd4: begin dr =  0; dc =  1; end
      3'd5: begin dr =  1; dc = -1; end
      3'd6: begin dr =  1; dc =  0; end
      default: begin dr = 1; dc = 1; end
    endcase
    nr      = q_row + dr;
    nc      = q_col + dc;
    nb_mine = 1'b0;
    if (q_in_range && nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS)
      nb_mine = out_mines[IDX_W'(nr * COLS + nc)];
    q_hit = 1'b0;
    if (q_in_range) q_hit = out_mines[q_idx];
  end

  // Main controller: placement, probing and serial neighbour counting
  always_ff @(posedge in_clka or posedge in_restart) begin
    if (in_restart) begin
      // NOTE: the mine bitmap is a plain register vector, not a RAM, so it is
      // cleared by reset along with every other output.
      state             <= ST_IDLE;
      out_field_valid   <= 1'b0;
      out_place_done    <= 1'b0;
      out_mines         <= '0;
      out_temp_index    <= '0;
      out_temp_mine_cnt <= '0;
      out_query_valid   <= 1'b0;
      out_query_hit     <= 1'b0;
      out_n_nearby      <= '0;
      target            <= '0;
      rej_cnt           <= '0;
      probe_ptr         <= '0;
      q_idx             <= '0;
      step              <= '0;
      acc               <= '0;
`ifdef SAFE_FIRST_EN
      safe_idx          <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout so every branch reads the
      // pre-edge register values regardless of statement order.
      out_place_done  <= 1'b0;
      out_query_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_place) begin
            state <= ST_INIT;
          end else if (in_query && out_field_valid) begin
            q_idx <= in_query_idx;
            step  <= '0;
            acc   <= '0;
            state <= ST_QUERY;
          end
        end
        ST_INIT: begin
          out_mines         <= '0;
          out_field_valid   <= 1'b0;
          out_temp_index    <= in_seed;
          out_temp_mine_cnt <= '0;
          rej_cnt           <= '0;
          target            <= target_next;
`ifdef SAFE_FIRST_EN
          safe_idx          <= in_safe_idx;
`endif
          state <= (target_next == '0) ? ST_DONE : ST_PLACE;
        end
        ST_PLACE: begin
          out_temp_index <= cand;
          if (cand_free) begin
            out_mines[cand]   <= 1'b1;
            out_temp_mine_cnt <= count_inc;
            rej_cnt           <= '0;
            if (target_hit) state <= ST_DONE;
          end else begin
            rej_cnt <= rej_cnt + 8'd1;
            if (int'(rej_cnt) + 1 >= RETRY_MAX) begin
              probe_ptr <= '0;
              state     <= ST_PROBE;
            end
          end
        end
        ST_PROBE: begin
          if (probe_free) begin
            out_mines[probe_ptr] <= 1'b1;
            out_temp_mine_cnt    <= count_inc;
            rej_cnt              <= '0;
            state                <= target_hit ? ST_DONE : ST_PLACE;
          end else begin
            probe_ptr <= probe_ptr + IDX_W'(1);
          end
        end
        ST_DONE: begin
          out_place_done  <= 1'b1;
          out_field_valid <= 1'b1;
          state           <= ST_IDLE;
        end
        ST_QUERY: begin
          acc  <= acc + {3'b000, nb_mine};
          step <= step + 3'd1;
          if (step == 3'd7) state <= ST_REPORT;
        end
        ST_REPORT: begin
          out_query_valid <= 1'b1;
          out_n_nearby    <= acc;
          out_query_hit   <= q_hit;
          state           <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mine_field_gen.sv
// tb_mine_field_gen: scoreboard bench for mine_field_gen on the default 5x5
// board. Stimulus tasks push expected results; a negedge monitor pops and
// compares whenever out_place_done or out_query_valid pulses.
// Expectations follow SAFE_FIRST_EN when that macro is defined.
module tb_mine_field_gen;

  localparam int IDX_W = 5;

`ifdef SAFE_FIRST_EN
  localparam logic [24:0] FIELD1  = 25'h0200003;
  localparam int          CLAMPED = 23;
`else
  localparam logic [24:0] FIELD1  = 25'h0202001;
  localparam int          CLAMPED = 24;
`endif

  logic             clk;
  logic             rst;
  logic             place;
  logic [IDX_W-1:0] seed, mult, incr, n_mines, safe_idx;
  logic             query;
  logic [IDX_W-1:0] query_idx;
  logic             busy, field_valid, place_done, query_valid, query_hit;
  logic [24:0]      mines;
  logic [IDX_W-1:0] temp_index, temp_mine_cnt;
  logic [3:0]       n_nearby;

  mine_field_gen dut (
    .in_clka          (clk),
    .in_restart       (rst),
    .in_place         (place),
    .in_seed          (seed),
    .in_mult          (mult),
    .in_incr          (incr),
    .in_n_mines       (n_mines),
    .in_safe_idx      (safe_idx),
    .in_query         (query),
    .in_query_idx     (query_idx),
    .out_busy         (busy),
    .out_field_valid  (field_valid),
    .out_place_done   (place_done),
    .out_mines        (mines),
    .out_temp_index   (temp_index),
    .out_temp_mine_cnt(temp_mine_cnt),
    .out_query_valid  (query_valid),
    .out_query_hit    (query_hit),
    .out_n_nearby     (n_nearby)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_query;
    string       name;
    logic [24:0] mines;
    bit          exact;
    int          cnt;
    int          nearby;
    bit          hit;
    int          at_cyc;  // -1: latency not checked
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare on every result pulse
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (place_done === 1'b1) begin
        if (sb.size() == 0 || sb[0].is_query) begin
          checks++; errors++;
          $display("FAIL unexpected_place_done: pulse at cycle %0d with no placement pending", cyc);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.exact) check({mon_e.name, "_mines"}, 64'(mines), 64'(mon_e.mines));
          else check({mon_e.name, "_popcount"}, 64'($countones(mines)), 64'(mon_e.cnt));
          check({mon_e.name, "_count"}, 64'(temp_mine_cnt), 64'(mon_e.cnt));
          if (mon_e.at_cyc >= 0) check({mon_e.name, "_latency"}, 64'(cyc), 64'(mon_e.at_cyc));
        end
      end
      if (query_valid === 1'b1) begin
        if (sb.size() == 0 || !sb[0].is_query) begin
          checks++; errors++;
          $display("FAIL unexpected_query_valid: pulse at cycle %0d with no query pending", cyc);
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.name, "_nearby"}, 64'(n_nearby), 64'(mon_e.nearby));
          check({mon_e.name, "_hit"}, 64'(query_hit), 64'(mon_e.hit));
          check({mon_e.name, "_latency"}, 64'(cyc), 64'(mon_e.at_cyc));
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 64'(busy), 64'(0));
  endtask

  // Push the expected placement result, then pulse in_place (optionally with in_query)
  task automatic start_place(input string name, input int s, input int m, input int i,
                             input int n, input int safe, input logic [24:0] exp_mines,
                             input bit exact, input int exp_cnt, input bit timed,
                             input bit with_query);
    exp_t e;
    @(negedge clk);
    seed = IDX_W'(s); mult = IDX_W'(m); incr = IDX_W'(i);
    n_mines = IDX_W'(n); safe_idx = IDX_W'(safe);
    place = 1'b1;
    query = with_query; query_idx = 5'd12;
    e.is_query = 1'b0; e.name = name; e.mines = exp_mines; e.exact = exact;
    e.cnt = exp_cnt; e.nearby = 0; e.hit = 1'b0;
    e.at_cyc = timed ? cyc + 1 + 2 : -1;
    sb.push_back(e);
    @(negedge clk);
    place = 1'b0;
    query = 1'b0;
  endtask

  task automatic push_query(input string name, input int nearby, input bit hit);
    exp_t e;
    e.is_query = 1'b1; e.name = name; e.mines = '0; e.exact = 1'b0; e.cnt = 0;
    e.nearby = nearby; e.hit = hit; e.at_cyc = cyc + 1 + 9;
    sb.push_back(e);
  endtask

  task automatic query_run(input string name, input int idx, input int nearby, input bit hit);
    @(negedge clk);
    query = 1'b1; query_idx = IDX_W'(idx);
    push_query(name, nearby, hit);
    @(negedge clk);
    query = 1'b0;
    wait_idle(name);
  endtask

  initial begin
    int n;
    place = 1'b0; query = 1'b0; query_idx = '0;
    seed = '0; mult = '0; incr = '0; n_mines = '0; safe_idx = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #20;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_field_valid", 64'(field_valid), 64'(0));
    check("rst_mines", 64'(mines), 64'(0));
    check("rst_temp_index", 64'(temp_index), 64'(0));
    check("rst_mine_cnt", 64'(temp_mine_cnt), 64'(0));
    check("rst_nearby", 64'(n_nearby), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Query before any field exists: must be ignored
    @(negedge clk); query = 1'b1; query_idx = 5'd3;
    @(negedge clk); query = 1'b0;
    repeat (12) @(negedge clk);
    check("noquery_busy", 64'(busy), 64'(0));

    // Main placement scenario
    start_place("place1", 0, 8, 13, 3, 13, FIELD1, 1'b1, 3, 1'b0, 1'b0);
    wait_idle("place1");
    check("place1_field_valid", 64'(field_valid), 64'(1));

    // Neighbour queries on the placed field
`ifdef SAFE_FIRST_EN
    query_run("q12", 12, 0, 1'b0);
    query_run("q0",   0, 1, 1'b1);
    query_run("q16", 16, 1, 1'b0);
    query_run("q6",   6, 2, 1'b0);
    query_run("q26", 26, 0, 1'b0);
`else
    query_run("q12", 12, 1, 1'b0);
    query_run("q0",   0, 0, 1'b1);
    query_run("q16", 16, 1, 1'b0);
    query_run("q7",   7, 1, 1'b0);
    query_run("q21", 21, 0, 1'b1);
    query_run("q20", 20, 1, 1'b0);
    query_run("q24", 24, 0, 1'b0);
    query_run("q26", 26, 0, 1'b0);
`endif

    // in_place while a query runs is ignored; field unchanged
    @(negedge clk);
    query = 1'b1; query_idx = 5'd16;
    push_query("q16_busy", 1, 1'b0);
    @(negedge clk); query = 1'b0; place = 1'b1; n_mines = 5'd0;
    @(negedge clk); place = 1'b0;
    wait_idle("q16_busy");
    repeat (3) @(negedge clk);
    check("busy_place_ignored_mines", 64'(mines), 64'(FIELD1));

    // in_place and in_query together: placement wins, no query pulse
    start_place("place_and_query", 0, 8, 13, 3, 13, FIELD1, 1'b1, 3, 1'b0, 1'b1);
    wait_idle("place_and_query");

    // in_query while placing is ignored
    start_place("place_busy_query", 0, 8, 13, 3, 13, FIELD1, 1'b1, 3, 1'b0, 1'b0);
    query = 1'b1; query_idx = 5'd12;
    @(negedge clk); query = 1'b0;
    wait_idle("place_busy_query");

    // Zero mines: done pulse two cycles after the accepting edge
    start_place("zero", 0, 8, 13, 0, 13, 25'h0, 1'b1, 0, 1'b1, 1'b0);
    wait_idle("zero");

    // Oversized request is clamped
    start_place("clamp", 0, 8, 13, 31, 13, 25'h0, 1'b0, CLAMPED, 1'b0, 1'b0);
    wait_idle("clamp");
`ifdef SAFE_FIRST_EN
    check("clamp_safe_free", 64'(mines[13]), 64'(0));
`endif

    // Async restart in the middle of PLACE
    start_place("aborted", 0, 8, 13, 3, 13, FIELD1, 1'b1, 3, 1'b0, 1'b0);
    n = 0;
    while (temp_mine_cnt != 5'd1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_first_accept", 64'(temp_mine_cnt), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_mines", 64'(mines), 64'(0));
    check("abort_mine_cnt", 64'(temp_mine_cnt), 64'(0));
    check("abort_temp_index", 64'(temp_index), 64'(0));
    check("abort_field_valid", 64'(field_valid), 64'(0));
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    start_place("after_restart", 0, 8, 13, 3, 13, FIELD1, 1'b1, 3, 1'b0, 1'b0);
    wait_idle("after_restart");

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d of %0d checks)", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/mine_field_gen.md
Name: mine_field_gen

Overview:
Parametrised successor of the fixed 5x5 mine-placement stage. It places a configurable number of mines on a ROWS x COLS board using a linear congruential generator (LCG). Collisions are resolved with bounded retry followed by a linear-probe fallback. After placement it answers neighbour-count queries serially, one neighbour per cycle, feeding the decode/ALU stages of the game FSM.

Parameters:
ROWS, 5, board rows
COLS, 5, board columns
IDX_W, 5, index/LCG width; 2^IDX_W >= ROWS*COLS
RETRY_MAX, 4, consecutive LCG rejects before linear-probe fallback

Ports:
in_clka  input  1  clock; all state updates on rising edge
in_restart  input  1  reset, asynchronous, active-high
in_place  input  1  start placement (sampled in IDLE)
in_seed  input  IDX_W  LCG start value
in_mult  input  IDX_W  LCG multiplier
in_incr  input  IDX_W  LCG increment
in_n_mines  input  IDX_W  requested mine count
in_safe_idx  input  IDX_W  protected cell (used only with SAFE_FIRST_EN)
in_query  input  1  neighbour-count request
in_query_idx  input  IDX_W  queried cell, row-major (idx = row*COLS+col)
out_busy  output  1  high in any state other than IDLE
out_field_valid  output  1  field placed and stable
out_place_done  output  1  one-cycle pulse when placement completes
out_mines  output  ROWS*COLS  mine bitmap, bit i = cell i
out_temp_index  output  IDX_W  current LCG value
out_temp_mine_cnt  output  IDX_W  mines placed so far
out_query_valid  output  1  one-cycle pulse, result valid
out_query_hit  output  1  queried cell holds a mine
out_n_nearby  output  4  neighbour mine count, 0..8

Behaviour:
- Reset (async): state IDLE; all outputs 0, including out_mines, counters, LCG register, and out_field_valid.
- States: IDLE, INIT, PLACE, PROBE, DONE, QUERY, REPORT.
- IDLE:
  - in_place=1 -> INIT; has priority over in_query.
  - in_query=1 with out_field_valid=1 -> latch in_query_idx, go to QUERY.
  - in_query with out_field_valid=0 is ignored.
- INIT (1 cycle):
  - clear out_mines and out_field_valid; LCG <= in_seed; mine count <= 0; reject counter <= 0.
  - target <= min(in_n_mines, CELLS-1), where CELLS=ROWS*COLS.
  - target 0 -> DONE; otherwise -> PLACE.
- PLACE (1 candidate per cycle):
  - cand = (LCG*in_mult + in_incr) mod 2^IDX_W; LCG <= cand.
  - Reject if cand >= CELLS or the cell is occupied; else accept: set bit, count++, reject counter <= 0.
  - count reaches target -> DONE.
  - reject counter reaching RETRY_MAX -> PROBE.
- PROBE:
  - probe pointer starts at 0 on each entry; examine one cell per cycle, ascending.
  - First free cell is accepted; reject counter <= 0; LCG unchanged.
  - Return to PLACE, or go to DONE if target reached.
  - Clamping guarantees a free cell always exists.
- DONE (1 cycle): out_place_done=1, out_field_valid <= 1, -> IDLE.
- QUERY (8 cycles):
  - Neighbours visited in order NW, N, NE, W, E, SW, S, SE.
  - Neighbours outside the board are skipped (count unchanged); no wrap across rows or columns.
  - Then -> REPORT.
- REPORT (1 cycle): out_query_valid=1, out_n_nearby and out_query_hit valid. Both hold their values until the next query.
- Latency: out_query_valid is high in the 10th cycle after the accepting edge.
- in_place or in_query received while out_busy=1 is ignored.
- in_query_idx >= CELLS: out_query_valid pulses with out_n_nearby=0 and out_query_hit=0.
- Arithmetic: all LCG arithmetic is truncated to IDX_W bits.

Optional Feature:
SAFE_FIRST_EN
- Defined:
  - A candidate equal to in_safe_idx is rejected in PLACE and skipped in PROBE.
  - Clamp becomes CELLS-2.
  - in_safe_idx is latched in INIT.
- Undefined: in_safe_idx is ignored; clamp is CELLS-1.

Test Plan:
- 5x5 board, seed=0, mult=8, incr=13, n_mines=3, macro off:
  - candidates 13 accepted, 21 accepted, then 21 rejected x4, probe accepts 0.
  - out_mines=25'h0202001; out_place_done pulses once; count=3.
- Same stimulus with SAFE_FIRST_EN, in_safe_idx=13:
  - 13 rejected, 21 accepted, probe accepts 0, probe accepts 1.
  - out_mines=25'h0200003.
- Field 25'h0202001, queries:
  - idx 12 -> n_nearby=1, hit=0.
  - idx 0 -> n_nearby=0, hit=1.
  - idx 16 -> n_nearby=1.
  - Each out_query_valid pulse occurs exactly 10 cycles after the accepting edge.
- n_mines=31, 5x5 board -> clamped to 24; out_mines popcount=24; exactly one cell 0; terminates via probe.
- Assert in_restart mid-PLACE (after first accept) -> all outputs 0 immediately, without waiting for a clock edge. A fresh in_place reproduces the first scenario's result.
- in_place and in_query asserted together in IDLE -> placement runs and no query pulse occurs. in_query while busy is ignored. n_mines=0 -> out_place_done 2 cycles after in_place, out_mines=0.
